// File: rtl/word_serializer_if.sv
// Handshake/stream bundle for word_serializer_ctrl: parallel word in, framed bit stream out.
// master = upstream producer / downstream consumer side, slave = the serializer.
interface word_serializer_if #(
   parameter int unsigned WORD_WIDTH = 16
);
   logic [WORD_WIDTH-1:0] inWord;
   logic                  inValid;
   logic                  inReady;
   logic                  outBit;
   logic                  outValid;
   logic                  outFirst;
   logic                  outLast;
   logic                  outStall;
   logic                  busy;

   modport master (
      output inWord, inValid, outStall,
      input  inReady, outBit, outValid, outFirst, outLast, busy
   );

   modport slave (
      input  inWord, inValid, outStall,
      output inReady, outBit, outValid, outFirst, outLast, busy
   );
endinterface

// File: rtl/word_serializer_ctrl.sv
// Parallel-to-bit-serial front end with first/last framing, consumer stall and debug stepping.
// Optional one-word skid buffer for gapless back-to-back words: define WORD_SERIALIZER_SKID_EN.
module word_serializer_ctrl #(
   parameter int unsigned DEBUG      = 1,
   parameter int unsigned WORD_WIDTH = 16,
   parameter int unsigned MSB_FIRST  = 1
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              dbg_clk_enable,
   word_serializer_if.slave  bus
);
   localparam int unsigned CNT_W = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORD_WIDTH - 1);

   if (WORD_WIDTH < 2) begin : g_chk_width
      $error("word_serializer_ctrl: WORD_WIDTH must be >= 2");
   end
   if (MSB_FIRST > 1) begin : g_chk_order
      $error("word_serializer_ctrl: MSB_FIRST must be 0 or 1");
   end

   typedef enum logic {S_IDLE = 1'b0, S_SHIFT = 1'b1} state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [WORD_WIDTH-1:0] r_shreg;
   logic [CNT_W-1:0]      r_bit_cnt;

   logic                  w_ce;
   logic                  w_last;
   logic                  w_advance;
   logic                  w_accept;
   logic                  w_in_ready;
   logic                  w_out_bit;
   logic                  w_out_valid;
   logic                  w_out_first;
   logic                  w_out_last;
   logic                  w_busy;
   logic                  w_shift_ready;
   logic                  w_skid_full;
   logic                  w_drain_skid;
   logic                  w_direct_load;
   logic [WORD_WIDTH-1:0] w_skid_word;
   logic [WORD_WIDTH-1:0] w_shifted;

   assign w_ce      = (DEBUG != 0) ? dbg_clk_enable : 1'b1;
   assign w_last    = (r_bit_cnt == LAST_CNT);
   assign w_advance = (r_state == S_SHIFT) & w_ce & ~bus.outStall;
   assign w_accept  = bus.inValid & w_in_ready;
   assign w_shifted = (MSB_FIRST != 0) ? (r_shreg << 1) : (r_shreg >> 1);

`ifdef WORD_SERIALIZER_SKID_EN
   logic                  r_skid_full;
   logic [WORD_WIDTH-1:0] r_skid_word;
   logic                  w_to_skid;

   // A word arriving on the last-bit advance with an empty skid bypasses it.
   assign w_direct_load = w_accept & w_advance & w_last & ~r_skid_full;
   assign w_to_skid     = w_accept & (r_state == S_SHIFT) & ~w_direct_load;
   assign w_drain_skid  = w_advance & w_last & r_skid_full;
   assign w_skid_full   = r_skid_full;
   assign w_skid_word   = r_skid_word;
   assign w_shift_ready = ~r_skid_full & w_ce & rstn;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_skid_full <= 1'b0;
         r_skid_word <= '0;
      end else if (w_ce) begin
         if (w_to_skid) begin
            r_skid_full <= 1'b1;
            r_skid_word <= bus.inWord;
         end else if (w_drain_skid) begin
            r_skid_full <= 1'b0;
         end
      end
   end
`else
   assign w_direct_load = 1'b0;
   assign w_drain_skid  = 1'b0;
   assign w_skid_full   = 1'b0;
   assign w_skid_word   = '0;
   assign w_shift_ready = 1'b0;
`endif

   // State register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         S_IDLE:  if (w_accept) w_state_nxt = S_SHIFT;
         S_SHIFT: if (w_advance & w_last & ~w_drain_skid & ~w_direct_load) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Shift register and bit counter
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_shreg   <= '0;
         r_bit_cnt <= '0;
      end else if (w_ce) begin
         if ((r_state == S_IDLE) && w_accept) begin
            r_shreg   <= bus.inWord;
            r_bit_cnt <= '0;
         end else if (w_direct_load) begin
            r_shreg   <= bus.inWord;
            r_bit_cnt <= '0;
         end else if (w_drain_skid) begin
            r_shreg   <= w_skid_word;
            r_bit_cnt <= '0;
         end else if (w_advance && !w_last) begin
            r_shreg   <= w_shifted;
            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
         end
      end
   end

   // Output decode
   always_comb begin
      w_in_ready  = 1'b0;
      w_out_valid = 1'b0;
      w_out_first = 1'b0;
      w_out_last  = 1'b0;
      w_out_bit   = 1'b0;
      w_busy      = w_skid_full;
      unique case (r_state)
         S_IDLE: w_in_ready = w_ce & rstn;
         S_SHIFT: begin
            w_in_ready  = w_shift_ready;
            w_out_valid = 1'b1;
            w_out_first = (r_bit_cnt == '0);
            w_out_last  = w_last;
            w_out_bit   = (MSB_FIRST != 0) ? r_shreg[WORD_WIDTH-1] : r_shreg[0];
            w_busy      = 1'b1;
         end
         default: ;
      endcase
   end

   assign bus.inReady  = w_in_ready;
   assign bus.outValid = w_out_valid;
   assign bus.outFirst = w_out_first;
   assign bus.outLast  = w_out_last;
   assign bus.outBit   = w_out_bit;
   assign bus.busy     = w_busy;
endmodule
